// File: rtl/twdl_mult_rn.sv
// twdl_mult_rn: multiplies sample k of each vector by W^k, with the powers of W built by a
// pipelined recursive complex-multiply chain. Define TWDL_OUT_SAT_EN to saturate the output.
module twdl_mult_rn #(
    parameter int unsigned WDATA     = 18,
    parameter int unsigned MAX_RADIX = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_val_i,
    input  logic [3:0]              radix_i,
    input  logic                    inverse_i,
    input  logic                    bypass_i,
    input  logic signed [15:0]      tw_real_i,
    input  logic signed [15:0]      tw_imag_i,
    input  logic signed [WDATA-1:0] din_real_i  [MAX_RADIX],
    input  logic signed [WDATA-1:0] din_imag_i  [MAX_RADIX],
    output logic                    out_val_o,
    output logic signed [WDATA-1:0] dout_real_o [MAX_RADIX],
    output logic signed [WDATA-1:0] dout_imag_o [MAX_RADIX]
);

    localparam int unsigned NSTEP = MAX_RADIX - 2;
    localparam int unsigned NPOS  = 2 * NSTEP + 1;
    localparam int unsigned LAST  = NPOS - 1;
    localparam int unsigned NPW   = MAX_RADIX - 1;
    localparam int unsigned NCP   = (NSTEP > 0) ? NSTEP : 1;
    localparam int unsigned PW    = WDATA + 16;
    localparam int unsigned SW    = WDATA + 17;

`ifdef TWDL_OUT_SAT_EN
    localparam logic signed [SW-1:0] OutMax = {{(SW-WDATA+1){1'b0}}, {(WDATA-1){1'b1}}};
    localparam logic signed [SW-1:0] OutMin = {{(SW-WDATA+1){1'b1}}, {(WDATA-1){1'b0}}};
`endif

    // Q2.14 power: round half up, then clamp to 16 bits.
    function automatic logic signed [15:0] rnd_pw(input logic signed [32:0] x);
        logic signed [32:0] t;
        t = (x + 33'sd8192) >>> 14;
        if (t > 33'sd32767) begin
            return 16'sh7fff;
        end else if (t < -33'sd32768) begin
            return 16'sh8000;
        end
        return t[15:0];
    endfunction

    function automatic logic signed [WDATA-1:0] rnd_out(input logic signed [SW-1:0] x);
        logic signed [SW-1:0] t;
        t = (x + SW'(8192)) >>> 14;
`ifdef TWDL_OUT_SAT_EN
        if (t > OutMax) begin
            t = OutMax;
        end else if (t < OutMin) begin
            t = OutMin;
        end
`endif
        return t[WDATA-1:0];
    endfunction

    // Pipeline positions: 0 is the input register, each power step adds a product and a sum.
    logic                    vld_q [NPOS];
    logic [3:0]              rdx_q [NPOS];
    logic signed [WDATA-1:0] dre_q [NPOS][MAX_RADIX];
    logic signed [WDATA-1:0] dim_q [NPOS][MAX_RADIX];
    // Entry j holds W^(j+1) once the chain has produced it.
    logic signed [15:0]      pre_q [NPOS][NPW];
    logic signed [15:0]      pim_q [NPOS][NPW];
    logic signed [31:0]      cp_q  [NCP][4];

    logic signed [PW-1:0]    mp_q  [NPW][4];
    logic signed [WDATA-1:0] mr0_q;
    logic signed [WDATA-1:0] mi0_q;
    logic [3:0]              mrdx_q;
    logic                    mvld_q;

    logic                    out_val_q;
    logic signed [WDATA-1:0] ore_q [MAX_RADIX];
    logic signed [WDATA-1:0] oim_q [MAX_RADIX];

    logic signed [15:0]      cap_wr;
    logic signed [15:0]      cap_wi;

    always_comb begin
        cap_wr = tw_real_i;
        cap_wi = tw_imag_i;
        if (bypass_i) begin
            cap_wr = 16'sd16384;
            cap_wi = '0;
        end else if (inverse_i) begin
            cap_wi = (tw_imag_i == 16'sh8000) ? 16'sh7fff : -tw_imag_i;
        end
    end

    // Datapath: no reset, validity is tracked separately and gates the outputs.
    always_ff @(posedge clk) begin
        if (in_val_i) begin
            rdx_q[0] <= radix_i;
            for (int k = 0; k < MAX_RADIX; k++) begin
                dre_q[0][k] <= din_real_i[k];
                dim_q[0][k] <= din_imag_i[k];
            end
            for (int k = 0; k < NPW; k++) begin
                pre_q[0][k] <= '0;
                pim_q[0][k] <= '0;
            end
            pre_q[0][0] <= cap_wr;
            pim_q[0][0] <= cap_wi;
        end

        for (int s = 0; s < NSTEP; s++) begin
            cp_q[s][0] <= 32'(pre_q[2*s][s]) * 32'(pre_q[2*s][0]);
            cp_q[s][1] <= 32'(pim_q[2*s][s]) * 32'(pim_q[2*s][0]);
            cp_q[s][2] <= 32'(pre_q[2*s][s]) * 32'(pim_q[2*s][0]);
            cp_q[s][3] <= 32'(pim_q[2*s][s]) * 32'(pre_q[2*s][0]);
            rdx_q[2*s+1] <= rdx_q[2*s];
            dre_q[2*s+1] <= dre_q[2*s];
            dim_q[2*s+1] <= dim_q[2*s];
            pre_q[2*s+1] <= pre_q[2*s];
            pim_q[2*s+1] <= pim_q[2*s];

            rdx_q[2*s+2] <= rdx_q[2*s+1];
            dre_q[2*s+2] <= dre_q[2*s+1];
            dim_q[2*s+2] <= dim_q[2*s+1];
            pre_q[2*s+2] <= pre_q[2*s+1];
            pim_q[2*s+2] <= pim_q[2*s+1];
            pre_q[2*s+2][s+1] <= rnd_pw({cp_q[s][0][31], cp_q[s][0]}
                                        - {cp_q[s][1][31], cp_q[s][1]});
            pim_q[2*s+2][s+1] <= rnd_pw({cp_q[s][2][31], cp_q[s][2]}
                                        + {cp_q[s][3][31], cp_q[s][3]});
        end

        for (int k = 1; k < MAX_RADIX; k++) begin
            mp_q[k-1][0] <= PW'(dre_q[LAST][k]) * PW'(pre_q[LAST][k-1]);
            mp_q[k-1][1] <= PW'(dim_q[LAST][k]) * PW'(pim_q[LAST][k-1]);
            mp_q[k-1][2] <= PW'(dre_q[LAST][k]) * PW'(pim_q[LAST][k-1]);
            mp_q[k-1][3] <= PW'(dim_q[LAST][k]) * PW'(pre_q[LAST][k-1]);
        end
        mr0_q  <= dre_q[LAST][0];
        mi0_q  <= dim_q[LAST][0];
        mrdx_q <= rdx_q[LAST];
    end

    // Valid chain and output register; results outside the active radix read as zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < NPOS; p++) begin
                vld_q[p] <= 1'b0;
            end
            mvld_q    <= 1'b0;
            out_val_q <= 1'b0;
            for (int k = 0; k < MAX_RADIX; k++) begin
                ore_q[k] <= '0;
                oim_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= in_val_i;
            for (int p = 1; p < NPOS; p++) begin
                vld_q[p] <= vld_q[p-1];
            end
            mvld_q    <= vld_q[LAST];
            out_val_q <= mvld_q;

            ore_q[0] <= '0;
            oim_q[0] <= '0;
            if (mvld_q && mrdx_q != 4'd0) begin
                ore_q[0] <= mr0_q;
                oim_q[0] <= mi0_q;
            end
            for (int k = 1; k < MAX_RADIX; k++) begin
                ore_q[k] <= '0;
                oim_q[k] <= '0;
                if (mvld_q && k < int'(mrdx_q)) begin
                    ore_q[k] <= rnd_out(SW'(mp_q[k-1][0]) - SW'(mp_q[k-1][1]));
                    oim_q[k] <= rnd_out(SW'(mp_q[k-1][2]) + SW'(mp_q[k-1][3]));
                end
            end
        end
    end

    assign out_val_o   = out_val_q;
    assign dout_real_o = ore_q;
    assign dout_imag_o = oim_q;

endmodule

// File: tb/tb_twdl_mult_rn.sv
// Self-checking bench for twdl_mult_rn: directed cases plus randomized streams checked
// against a complex-arithmetic reference model.
module tb_twdl_mult_rn;

    localparam int WD  = 18;
    localparam int MR  = 5;
    localparam int LAT = 2 * MR - 1;
    localparam int NS  = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_val;
    logic [3:0]           radix;
    logic                 inverse;
    logic                 bypass;
    logic signed [15:0]   tw_real;
    logic signed [15:0]   tw_imag;
    logic signed [WD-1:0] din_real  [MR];
    logic signed [WD-1:0] din_imag  [MR];
    logic                 out_val;
    logic signed [WD-1:0] dout_real [MR];
    logic signed [WD-1:0] dout_imag [MR];

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]           s_rdx [NS];
    logic                 s_inv [NS];
    logic                 s_byp [NS];
    logic signed [15:0]   s_wr  [NS];
    logic signed [15:0]   s_wi  [NS];
    logic signed [WD-1:0] s_dr  [NS][MR];
    logic signed [WD-1:0] s_di  [NS][MR];
    int                   exp_r [NS][MR];
    int                   exp_i [NS][MR];

    twdl_mult_rn #(.WDATA(WD), .MAX_RADIX(MR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_val_i    (in_val),
        .radix_i     (radix),
        .inverse_i   (inverse),
        .bypass_i    (bypass),
        .tw_real_i   (tw_real),
        .tw_imag_i   (tw_imag),
        .din_real_i  (din_real),
        .din_imag_i  (din_imag),
        .out_val_o   (out_val),
        .dout_real_o (dout_real),
        .dout_imag_o (dout_imag)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic longint rnd14(longint x);
        return (x + 64'sd8192) >>> 14;
    endfunction

    function automatic longint sat16(longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic longint fit_out(longint x);
        longint m;
`ifdef TWDL_OUT_SAT_EN
        if (x > 131071) return 131071;
        if (x < -131072) return -131072;
        return x;
`else
        m = x & 64'sd262143;
        if (m >= 131072) m = m - 262144;
        return m;
`endif
    endfunction

    // Reference: sample k times W^k, powers built by repeated rounded complex products.
    function automatic void model(int i);
        longint wr, wi, pr, pi, tr, ti, dr, di;
        wr = s_byp[i] ? 64'sd16384 : longint'(s_wr[i]);
        wi = s_byp[i] ? 64'sd0 : longint'(s_wi[i]);
        if (!s_byp[i] && s_inv[i]) wi = (wi == -32768) ? 64'sd32767 : -wi;
        pr = 16384;
        pi = 0;
        for (int k = 0; k < MR; k++) begin
            if (k == 1) begin
                pr = wr;
                pi = wi;
            end else if (k >= 2) begin
                tr = sat16(rnd14(pr * wr - pi * wi));
                ti = sat16(rnd14(pr * wi + pi * wr));
                pr = tr;
                pi = ti;
            end
            dr = longint'(s_dr[i][k]);
            di = longint'(s_di[i][k]);
            if (k >= int'(s_rdx[i])) begin
                exp_r[i][k] = 0;
                exp_i[i][k] = 0;
            end else begin
                exp_r[i][k] = int'(fit_out(rnd14(dr * pr - di * pi)));
                exp_i[i][k] = int'(fit_out(rnd14(dr * pi + di * pr)));
            end
        end
    endfunction

    task automatic put(int i);
        in_val  = 1'b1;
        radix   = s_rdx[i];
        inverse = s_inv[i];
        bypass  = s_byp[i];
        tw_real = s_wr[i];
        tw_imag = s_wi[i];
        for (int k = 0; k < MR; k++) begin
            din_real[k] = s_dr[i][k];
            din_imag[k] = s_di[i][k];
        end
    endtask

    // Called at a negedge with inputs set; returns at the negedge where the result is visible.
    task automatic fire();
        in_val = 1'b1;
        @(negedge clk);
        in_val = 1'b0;
        repeat (LAT - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        in_val  = 1'b1;
        radix   = 4'd5;
        tw_real = 16'sd16384;
        tw_imag = 16'sd0;
        for (int k = 0; k < MR; k++) begin
            din_real[k] = 18'sd1234;
            din_imag[k] = -18'sd77;
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (out_val !== 1'b0) $display("FAIL reset_out_val: got %0b want 0", out_val);
        if (out_val !== 1'b0) n_fail++;
        for (int k = 0; k < MR; k++) begin
            n_tests++;
            if (dout_real[k] !== 0 || dout_imag[k] !== 0) begin
                n_fail++;
                $display("FAIL reset_dout[%0d]: got (%0d,%0d) want (0,0)", k,
                         dout_real[k], dout_imag[k]);
            end
        end
        in_val = 1'b0;
        rst_n  = 1'b1;
        for (int j = 0; j < LAT + 2; j++) begin
            @(negedge clk);
            n_tests++;
            if (out_val !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release_idle: cycle %0d got out_val %0b want 0", j, out_val);
            end
        end
    endtask

    task automatic test_unity();
        radix   = 4'd5;
        inverse = 1'b0;
        bypass  = 1'b0;
        tw_real = 16'sd16384;
        tw_imag = 16'sd0;
        for (int k = 0; k < MR; k++) begin
            din_real[k] = 18'sd1000;
            din_imag[k] = -18'sd500;
        end
        in_val = 1'b1;
        @(negedge clk);
        in_val = 1'b0;
        repeat (LAT - 2) @(negedge clk);
        n_tests++;
        if (out_val !== 1'b0) begin
            n_fail++;
            $display("FAIL unity_early: got out_val %0b want 0", out_val);
        end
        @(negedge clk);
        n_tests++;
        if (out_val !== 1'b1) begin
            n_fail++;
            $display("FAIL unity_out_val: got %0b want 1", out_val);
        end
        for (int k = 0; k < MR; k++) begin
            n_tests++;
            if (dout_real[k] !== 1000 || dout_imag[k] !== -500) begin
                n_fail++;
                $display("FAIL unity_dout[%0d]: got (%0d,%0d) want (1000,-500)", k,
                         dout_real[k], dout_imag[k]);
            end
        end
        @(negedge clk);
        n_tests++;
        if (out_val !== 1'b0 || dout_real[0] !== 0) begin
            n_fail++;
            $display("FAIL unity_single: got out_val %0b dout0 %0d want 0,0", out_val,
                     dout_real[0]);
        end
    endtask

    task automatic test_minus_j();
        int er [MR];
        int ei [MR];
        for (int pass = 0; pass < 2; pass++) begin
            radix   = 4'd4;
            inverse = pass[0];
            bypass  = 1'b0;
            tw_real = 16'sd0;
            tw_imag = -16'sd16384;
            din_real[0] = 18'sd7;
            din_imag[0] = -18'sd7;
            for (int k = 1; k < 4; k++) begin
                din_real[k] = 18'sd1000;
                din_imag[k] = 18'sd0;
            end
            din_real[4] = 18'sd555;
            din_imag[4] = 18'sd555;
            er = '{7, 0, -1000, 0, 0};
            ei = (pass == 0) ? '{-7, -1000, 0, 1000, 0} : '{-7, 1000, 0, -1000, 0};
            fire();
            n_tests++;
            if (out_val !== 1'b1) begin
                n_fail++;
                $display("FAIL minus_j_out_val[inv=%0d]: got %0b want 1", pass, out_val);
            end
            for (int k = 0; k < MR; k++) begin
                n_tests++;
                if (dout_real[k] !== er[k] || dout_imag[k] !== ei[k]) begin
                    n_fail++;
                    $display("FAIL minus_j_dout[inv=%0d][%0d]: got (%0d,%0d) want (%0d,%0d)",
                             pass, k, dout_real[k], dout_imag[k], er[k], ei[k]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rounding();
        logic signed [WD-1:0] d0r, d0i;
        d0r = WD'($urandom);
        d0i = WD'($urandom);
        radix   = 4'd2;
        inverse = 1'b0;
        bypass  = 1'b0;
        tw_real = 16'sd8192;
        tw_imag = 16'sd0;
        din_real[0] = d0r;
        din_imag[0] = d0i;
        din_real[1] = 18'sd3;
        din_imag[1] = -18'sd3;
        din_real[2] = 18'sd99;
        din_imag[2] = 18'sd99;
        fire();
        n_tests++;
        if (dout_real[1] !== 2 || dout_imag[1] !== -1) begin
            n_fail++;
            $display("FAIL round_half: got (%0d,%0d) want (2,-1)", dout_real[1], dout_imag[1]);
        end
        n_tests++;
        if (dout_real[0] !== d0r || dout_imag[0] !== d0i) begin
            n_fail++;
            $display("FAIL round_ch0: got (%0d,%0d) want (%0d,%0d)", dout_real[0],
                     dout_imag[0], d0r, d0i);
        end
        n_tests++;
        if (dout_real[2] !== 0 || dout_imag[2] !== 0) begin
            n_fail++;
            $display("FAIL round_radix_gate: got (%0d,%0d) want (0,0)", dout_real[2],
                     dout_imag[2]);
        end
        @(negedge clk);
        bypass  = 1'b1;
        inverse = 1'b1;
        radix   = 4'd5;
        tw_real = 16'($urandom);
        tw_imag = 16'($urandom);
        for (int k = 2; k < MR; k++) begin
            din_real[k] = WD'($urandom);
            din_imag[k] = WD'($urandom);
        end
        fire();
        for (int k = 0; k < MR; k++) begin
            n_tests++;
            if (dout_real[k] !== din_real[k] || dout_imag[k] !== din_imag[k]) begin
                n_fail++;
                $display("FAIL bypass_dout[%0d]: got (%0d,%0d) want (%0d,%0d)", k,
                         dout_real[k], dout_imag[k], din_real[k], din_imag[k]);
            end
        end
        @(negedge clk);
        bypass  = 1'b0;
        inverse = 1'b0;
    endtask

    task automatic test_saturation();
        int want_pos, want_neg;
`ifdef TWDL_OUT_SAT_EN
        want_pos = 131071;
        want_neg = -131072;
`else
        want_pos = -2;
        want_neg = 0;
`endif
        radix   = 4'd2;
        tw_real = 16'sd16384;
        tw_imag = 16'sd16384;
        din_real[1] = 18'sd131071;
        din_imag[1] = 18'sd131071;
        fire();
        n_tests++;
        if (dout_real[1] !== 0 || dout_imag[1] !== want_pos) begin
            n_fail++;
            $display("FAIL sat_pos: got (%0d,%0d) want (0,%0d)", dout_real[1], dout_imag[1],
                     want_pos);
        end
        @(negedge clk);
        din_real[1] = -18'sd131072;
        din_imag[1] = -18'sd131072;
        fire();
        n_tests++;
        if (dout_real[1] !== 0 || dout_imag[1] !== want_neg) begin
            n_fail++;
            $display("FAIL sat_neg: got (%0d,%0d) want (0,%0d)", dout_real[1], dout_imag[1],
                     want_neg);
        end
        @(negedge clk);
    endtask

    task automatic test_stream();
        localparam int N = 20;
        int  v;
        logic ev;
        int  wr, wi;
        for (int i = 0; i < N; i++) begin
            s_rdx[i] = (i % 2 == 0) ? 4'd3 : 4'd5;
            s_inv[i] = i[0];
            s_byp[i] = 1'b0;
            s_wr[i]  = 16'($urandom);
            s_wi[i]  = 16'($urandom);
            if (i % 5 == 4) s_wi[i] = 16'sh8000;
            for (int k = 0; k < MR; k++) begin
                s_dr[i][k] = WD'($urandom);
                s_di[i][k] = WD'($urandom);
            end
            model(i);
        end
        for (int j = 0; j < N + LAT + 2; j++) begin
            @(negedge clk);
            v  = j - LAT;
            ev = (v >= 0 && v < N);
            n_tests++;
            if (out_val !== ev) begin
                n_fail++;
                $display("FAIL stream_out_val: cycle %0d got %0b want %0b", j, out_val, ev);
            end
            for (int k = 0; k < MR; k++) begin
                wr = ev ? exp_r[v][k] : 0;
                wi = ev ? exp_i[v][k] : 0;
                n_tests++;
                if (dout_real[k] !== wr || dout_imag[k] !== wi) begin
                    n_fail++;
                    $display("FAIL stream_dout: vec %0d ch %0d got (%0d,%0d) want (%0d,%0d)",
                             v, k, dout_real[k], dout_imag[k], wr, wi);
                end
            end
            if (j < N) put(j);
            else in_val = 1'b0;
        end
    endtask

    task automatic test_reset_midstream();
        localparam int N = 6;
        int  v;
        logic ev;
        int  wr, wi;
        for (int i = 0; i < N; i++) begin
            s_rdx[i] = 4'd5;
            s_inv[i] = 1'($urandom);
            s_byp[i] = (i == 5);
            s_wr[i]  = 16'($urandom);
            s_wi[i]  = 16'($urandom);
            for (int k = 0; k < MR; k++) begin
                s_dr[i][k] = WD'($urandom);
                s_di[i][k] = WD'($urandom);
            end
            model(i);
        end
        for (int j = 0; j < N + LAT + 2; j++) begin
            @(negedge clk);
            v  = j - LAT;
            ev = (v == 4 || v == 5);
            n_tests++;
            if (out_val !== ev) begin
                n_fail++;
                $display("FAIL midreset_out_val: cycle %0d got %0b want %0b", j, out_val, ev);
            end
            for (int k = 0; k < MR; k++) begin
                wr = ev ? exp_r[v][k] : 0;
                wi = ev ? exp_i[v][k] : 0;
                n_tests++;
                if (dout_real[k] !== wr || dout_imag[k] !== wi) begin
                    n_fail++;
                    $display("FAIL midreset_dout: cycle %0d ch %0d got (%0d,%0d) want (%0d,%0d)",
                             j, k, dout_real[k], dout_imag[k], wr, wi);
                end
            end
            rst_n = (j == 3) ? 1'b0 : 1'b1;
            if (j < N) put(j);
            else in_val = 1'b0;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        in_val  = 1'b0;
        radix   = 4'd0;
        inverse = 1'b0;
        bypass  = 1'b0;
        tw_real = '0;
        tw_imag = '0;
        for (int k = 0; k < MR; k++) begin
            din_real[k] = '0;
            din_imag[k] = '0;
        end
        @(negedge clk);
        test_reset();
        test_unity();
        test_minus_j();
        test_rounding();
        test_saturation();
        test_stream();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
